// File: rtl/mem_responder_if.sv
// mem_responder_if
//   Request/response bus between the CPU side (master) and the wait-stated
//   word RAM (slave).
//   req   : transfer request, held with we/a/wd stable until ready
//   we    : 1 = write, 0 = read
//   a     : byte address
//   wd    : write data
//   rd    : read data, meaningful only while ready=1
//   ready : one-cycle response strobe
//   err   : error flag, meaningful only while ready=1
interface mem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        ready;
   logic        err;

   modport master (output req, we, a, wd, input rd, ready, err);
   modport slave  (input req, we, a, wd, output rd, ready, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder
//   Handshaked, wait-stated word RAM answering the multicycle MIPS core's
//   unified instruction/data bus.  A request accepted in IDLE spends
//   WAIT_CYCLES cycles in WAIT and then responds for exactly one cycle in RESP.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous, active-low reset
//     bus   : mem_responder_if slave modport (req/we/a/wd in, rd/ready/err out)
//   Parameters:
//     DEPTH_WORDS : number of 32-bit words
//     WAIT_CYCLES : cycles spent in WAIT before the response (0..15)
//   Optional feature, macro RESP_ERR_EN:
//     defined   - misaligned or out-of-range accesses respond with err=1,
//                 writes are suppressed and rd=0
//     undefined - err is always 0, a[1:0] is ignored, index wraps
module mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            reset,
   mem_responder_if.slave  bus
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t             state, state_nxt;
   logic [3:0]         cnt, cnt_nxt;
   logic               resp_nxt;

   // Request attributes captured at acceptance; WAIT and RESP use only these.
   logic [IDX_W-1:0]   lat_idx;
   logic               lat_we;
   logic [31:0]        lat_wd;
   logic               lat_err;

   logic [31:0]        mem [DEPTH_WORDS];

   logic [31:0]        rd_q, rd_nxt;
   logic               ready_q, err_q;

   logic               in_err;
   logic [IDX_W-1:0]   cur_idx;
   logic               cur_we;
   logic               cur_err;
   logic               unused_bits;

`ifdef RESP_ERR_EN
   function automatic logic addr_err(input logic [31:0] addr);
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
   endfunction

   assign in_err = addr_err(bus.a);
`else
   assign in_err = 1'b0;
`endif

   // Address bits beyond the word index only matter for the error check.
   assign unused_bits = ^bus.a;

   // With WAIT_CYCLES=0 the response is loaded on the accepting edge, so the
   // attributes must come straight from the bus rather than the latches.
   assign cur_idx = (state == S_IDLE) ? bus.a[IDX_W+1:2] : lat_idx;
   assign cur_we  = (state == S_IDLE) ? bus.we : lat_we;
   assign cur_err = (state == S_IDLE) ? in_err : lat_err;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      resp_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.req) begin
               if (WAIT_CYCLES == 0) begin
                  state_nxt = S_RESP;
                  resp_nxt  = 1'b1;
               end else begin
                  state_nxt = S_WAIT;
                  cnt_nxt   = 4'(WAIT_CYCLES - 1);
               end
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) begin
               state_nxt = S_RESP;
               resp_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         S_RESP: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Outputs are registered: they are prepared on the edge that enters RESP.
   always_comb begin
      rd_nxt = 32'd0;
      if (resp_nxt && !cur_we && !cur_err) begin
         rd_nxt = mem[cur_idx];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         rd_q    <= 32'd0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         ready_q <= resp_nxt;
         err_q   <= resp_nxt & cur_err;
         rd_q    <= rd_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && bus.req) begin
         lat_idx <= bus.a[IDX_W+1:2];
         lat_we  <= bus.we;
         lat_wd  <= bus.wd;
         lat_err <= in_err;
      end
   end

   // The write lands at the end of RESP.  An asynchronous reset during RESP
   // forces state to IDLE before the edge, so a pending write is dropped.
   always_ff @(posedge clk) begin
      if (state == S_RESP && lat_we && !lat_err) begin
         mem[lat_idx] <= lat_wd;
      end
   end

   assign bus.rd    = rd_q;
   assign bus.ready = ready_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Two responders share clock and reset: dut0 with the default two wait
//   cycles and dut1 with zero wait cycles.  Expected responses come from a
//   word-array reference model kept in this bench.
module tb_mem_responder;

   localparam int DEPTH = 64;

   logic clk;
   logic reset;

   int n_checks;
   int n_fail;

   mem_responder_if if0();
   mem_responder_if if1();

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (if0)
   );

   mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: one word array per responder.
   logic [31:0] mdl_mem [2][DEPTH];
   bit          mdl_vld [2][DEPTH];

   function automatic int wait_of(input int which);
      return (which == 0) ? 2 : 0;
   endfunction

   function automatic bit model_err(input logic [31:0] addr);
`ifdef RESP_ERR_EN
      return ((addr % 4) != 0) || ((addr / 4) >= DEPTH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int model_idx(input logic [31:0] addr);
      return int'((addr / 4) % DEPTH);
   endfunction

   // Applies one transfer to the model and returns the expected response.
   function automatic void model_access(input int which, input bit we_i,
                                        input logic [31:0] a_i, input logic [31:0] wd_i,
                                        output logic [31:0] exp_rd, output bit exp_err,
                                        output bit known);
      int idx;
      idx     = model_idx(a_i);
      exp_err = model_err(a_i);
      exp_rd  = 32'd0;
      known   = 1'b1;
      if (!exp_err) begin
         if (we_i) begin
            mdl_mem[which][idx] = wd_i;
            mdl_vld[which][idx] = 1'b1;
         end else begin
            exp_rd = mdl_mem[which][idx];
            known  = mdl_vld[which][idx];
         end
      end
   endfunction

   function automatic logic get_ready(input int which);
      return (which == 0) ? if0.ready : if1.ready;
   endfunction

   function automatic logic get_err(input int which);
      return (which == 0) ? if0.err : if1.err;
   endfunction

   function automatic logic [31:0] get_rd(input int which);
      return (which == 0) ? if0.rd : if1.rd;
   endfunction

   task automatic drive(input int which, input bit req_i, input bit we_i,
                        input logic [31:0] a_i, input logic [31:0] wd_i);
      if (which == 0) begin
         if0.req = req_i; if0.we = we_i; if0.a = a_i; if0.wd = wd_i;
      end else begin
         if1.req = req_i; if1.we = we_i; if1.a = a_i; if1.wd = wd_i;
      end
   endtask

   // One complete transfer.  Called and returns at #1 after a rising edge with
   // the responder idle.  lat_o counts edges from acceptance to ready (-1 on
   // timeout); quiet_o is cleared if rd/err were nonzero before ready.
   task automatic xfer(input int which, input bit we_i, input logic [31:0] a_i,
                       input logic [31:0] wd_i, output logic [31:0] rd_o,
                       output logic err_o, output int lat_o, output bit quiet_o);
      bit done;
      done    = 1'b0;
      quiet_o = 1'b1;
      lat_o   = -1;
      rd_o    = 32'd0;
      err_o   = 1'b0;
      drive(which, 1'b1, we_i, a_i, wd_i);
      for (int n = 1; n <= 40 && !done; n++) begin
         @(posedge clk); #1;
         if (get_ready(which) === 1'b1) begin
            lat_o = n;
            rd_o  = get_rd(which);
            err_o = get_err(which);
            done  = 1'b1;
         end else if (get_rd(which) !== 32'd0 || get_err(which) !== 1'b0) begin
            quiet_o = 1'b0;
         end
      end
      drive(which, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int c = 0; c < 6; c++) begin
         drive(0, c[0], 1'b0, 32'h10, 32'd0);
         drive(1, c[0], 1'b1, 32'h20, 32'hFFFF_FFFF);
         @(posedge clk); #1;
         n_checks++;
         if ({if0.ready, if0.err, if0.rd} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_dut0 cycle %0d: ready=%b err=%b rd=%h, required all 0",
                     c, if0.ready, if0.err, if0.rd);
         end
         n_checks++;
         if ({if1.ready, if1.err, if1.rd} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_dut1 cycle %0d: ready=%b err=%b rd=%h, required all 0",
                     c, if1.ready, if1.err, if1.rd);
         end
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   // Give every word a defined value so later reads are predictable.
   task automatic init_mem();
      logic [31:0] rd_v, erd;
      logic        err_v;
      bit          eerr, known, quiet;
      int          lat;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            model_access(w, 1'b1, 32'(i * 4), d, erd, eerr, known);
            xfer(w, 1'b1, 32'(i * 4), d, rd_v, err_v, lat, quiet);
         end
      end
   endtask

   task automatic test_write_read();
      logic [31:0] rd_v, erd;
      logic        err_v;
      bit          eerr, known, quiet;
      int          lat;
      model_access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, erd, eerr, known);
      xfer(0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd_v, err_v, lat, quiet);
      n_checks++;
      if (lat !== 3) begin
         n_fail++;
         $display("FAIL write_latency: got %0d cycles, required 3", lat);
      end
      n_checks++;
      if (err_v !== 1'b0 || rd_v !== 32'd0 || !quiet) begin
         n_fail++;
         $display("FAIL write_resp: err=%b rd=%h quiet=%0d, required err=0 rd=0 quiet=1",
                  err_v, rd_v, quiet);
      end
      model_access(0, 1'b0, 32'h10, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h10, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (lat !== 3 || rd_v !== 32'hDEAD_BEEF || err_v !== 1'b0) begin
         n_fail++;
         $display("FAIL read_after_write: lat=%0d rd=%h err=%b, required lat=3 rd=deadbeef err=0",
                  lat, rd_v, err_v);
      end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd_v, erd;
      logic        err_v;
      bit          eerr, known, quiet;
      int          lat;
      model_access(1, 1'b0, 32'h0, 32'd0, erd, eerr, known);
      xfer(1, 1'b0, 32'h0, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (lat !== 1 || rd_v !== erd || err_v !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_wait_read: lat=%0d rd=%h err=%b, required lat=1 rd=%h err=0",
                  lat, rd_v, err_v, erd);
      end
   endtask

   // req held high: a new transfer every WAIT_CYCLES+2 cycles.
   task automatic test_back_to_back();
      logic [31:0] erd;
      bit          eerr, known;
      for (int w = 0; w < 2; w++) begin
         int period;
         period = wait_of(w) + 2;
         model_access(w, 1'b0, 32'h8, 32'd0, erd, eerr, known);
         drive(w, 1'b1, 1'b0, 32'h8, 32'd0);
         for (int c = 1; c <= 8; c++) begin
            logic exp_rdy;
            @(posedge clk); #1;
            exp_rdy = ((c % period) == (wait_of(w) + 1) % period);
            n_checks++;
            if (get_ready(w) !== exp_rdy ||
                get_rd(w) !== (exp_rdy ? erd : 32'd0)) begin
               n_fail++;
               $display("FAIL back_to_back dut%0d cycle %0d: ready=%b rd=%h, required ready=%b rd=%h",
                        w, c, get_ready(w), get_rd(w), exp_rdy, exp_rdy ? erd : 32'd0);
            end
         end
         drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_error();
      logic [31:0] rd_v, erd, prior;
      logic        err_v;
      bit          eerr, known, quiet;
      int          lat;
      // Misaligned write near word 0x10.
      model_access(0, 1'b1, 32'h12, 32'h5555_AAAA, erd, eerr, known);
      xfer(0, 1'b1, 32'h12, 32'h5555_AAAA, rd_v, err_v, lat, quiet);
      n_checks++;
      if (err_v !== 1'(eerr) || rd_v !== 32'd0) begin
         n_fail++;
         $display("FAIL misaligned_write: err=%b rd=%h, required err=%b rd=0", err_v, rd_v, eerr);
      end
      model_access(0, 1'b0, 32'h10, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h10, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (rd_v !== erd || err_v !== 1'b0) begin
         n_fail++;
         $display("FAIL word_0x10_after_misaligned: rd=%h err=%b, required rd=%h err=0",
                  rd_v, err_v, erd);
      end
      // Out-of-range read: error, or alias of word 0 when checking is off.
      prior = mdl_mem[0][0];
      model_access(0, 1'b0, 32'h100, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h100, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
`ifdef RESP_ERR_EN
      if (err_v !== 1'b1 || rd_v !== 32'd0) begin
         n_fail++;
         $display("FAIL out_of_range_read: err=%b rd=%h, required err=1 rd=0", err_v, rd_v);
      end
`else
      if (err_v !== 1'b0 || rd_v !== prior) begin
         n_fail++;
         $display("FAIL alias_read_0x100: err=%b rd=%h, required err=0 rd=%h", err_v, rd_v, prior);
      end
`endif
   endtask

   task automatic test_reset_mid_op();
      logic [31:0] rd_v, erd, prior;
      logic        err_v;
      bit          eerr, known, quiet, saw_ready;
      int          lat;
      // Reset during WAIT.
      prior = mdl_mem[0][8];
      drive(0, 1'b1, 1'b1, 32'h20, 32'h1234);
      @(posedge clk); #1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      saw_ready = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) reset = 1'b1;
         @(posedge clk); #1;
         if (if0.ready !== 1'b0) saw_ready = 1'b1;
      end
      n_checks++;
      if (saw_ready) begin
         n_fail++;
         $display("FAIL reset_in_wait_ready: ready seen=1, required 0");
      end
      model_access(0, 1'b0, 32'h20, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h20, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (rd_v !== prior) begin
         n_fail++;
         $display("FAIL reset_in_wait_data: rd=%h, required %h", rd_v, prior);
      end
      // Reset during RESP of a write: ready drops at once, write discarded.
      prior = mdl_mem[0][9];
      drive(0, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D);
      saw_ready = 1'b0;
      for (int n = 0; n < 10 && !saw_ready; n++) begin
         @(posedge clk); #1;
         if (if0.ready === 1'b1) saw_ready = 1'b1;
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      reset = 1'b0;
      #1;
      n_checks++;
      if (!saw_ready || if0.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_resp_ready: reached_resp=%0d ready=%b, required 1 and 0",
                  saw_ready, if0.ready);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      model_access(0, 1'b0, 32'h24, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h24, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (rd_v !== prior) begin
         n_fail++;
         $display("FAIL reset_in_resp_data: rd=%h, required %h", rd_v, prior);
      end
   endtask

   task automatic test_input_change();
      logic [31:0] rd_v, erd, d_first, d_second;
      logic        err_v;
      bit          eerr, known, quiet, saw_ready;
      int          lat;
      d_first  = $urandom;
      d_second = ~d_first;
      drive(0, 1'b1, 1'b1, 32'h30, d_first);
      @(posedge clk); #1;
      drive(0, 1'b1, 1'b1, 32'h34, d_second);
      saw_ready = 1'b0;
      err_v = 1'b1;
      for (int n = 0; n < 10 && !saw_ready; n++) begin
         @(posedge clk); #1;
         if (if0.ready === 1'b1) begin
            saw_ready = 1'b1;
            err_v = if0.err;
         end
      end
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(posedge clk); #1;
      model_access(0, 1'b1, 32'h30, d_first, erd, eerr, known);
      n_checks++;
      if (!saw_ready || err_v !== 1'b0) begin
         n_fail++;
         $display("FAIL input_change_resp: ready_seen=%0d err=%b, required 1 and 0", saw_ready, err_v);
      end
      model_access(0, 1'b0, 32'h30, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h30, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (rd_v !== erd) begin
         n_fail++;
         $display("FAIL input_change_latched_word: rd=%h, required %h", rd_v, erd);
      end
      model_access(0, 1'b0, 32'h34, 32'd0, erd, eerr, known);
      xfer(0, 1'b0, 32'h34, 32'd0, rd_v, err_v, lat, quiet);
      n_checks++;
      if (rd_v !== erd) begin
         n_fail++;
         $display("FAIL input_change_other_word: rd=%h, required %h", rd_v, erd);
      end
   endtask

   task automatic test_random();
      logic [31:0] rd_v, erd, a_v, d_v;
      logic        err_v;
      bit          eerr, known, quiet, we_v;
      int          lat, which, kind;
      for (int i = 0; i < 60; i++) begin
         which = int'($urandom_range(0, 1));
         we_v  = 1'($urandom_range(0, 1));
         kind  = int'($urandom_range(0, 9));
         if (kind < 7)       a_v = 32'($urandom_range(0, DEPTH - 1)) * 4;
         else if (kind == 7) a_v = 32'($urandom_range(0, 4 * DEPTH - 1));
         else                a_v = 32'($urandom_range(DEPTH, 1023)) * 4;
         d_v = $urandom;
         model_access(which, we_v, a_v, d_v, erd, eerr, known);
         xfer(which, we_v, a_v, d_v, rd_v, err_v, lat, quiet);
         n_checks++;
         if (lat !== wait_of(which) + 1 || err_v !== 1'(eerr) || !quiet ||
             (known && rd_v !== erd)) begin
            n_fail++;
            $display("FAIL random[%0d] dut%0d we=%0d a=%h: lat=%0d err=%b rd=%h quiet=%0d, required lat=%0d err=%b rd=%h quiet=1",
                     i, which, we_v, a_v, lat, err_v, rd_v, quiet,
                     wait_of(which) + 1, eerr, erd);
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      for (int w = 0; w < 2; w++)
         for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[w][i] = 32'd0;
            mdl_vld[w][i] = 1'b0;
         end
      test_reset();
      init_mem();
      test_write_read();
      test_zero_wait();
      test_back_to_back();
      test_error();
      test_reset_mid_op();
      test_input_change();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
